prog_loader: RTL

- Parametrised successor to the switch-driven memory programming logic.
- Turns each press of a raw `enter` button into exactly one single-cycle write of the `switch` value into a DEPTH-entry memory.
- Supports three modes: append, direct-address and clear-all.
- Tracks fill level, flags overflow and bad addresses, and sits between the board I/O and the write port of the program/data RAM.

---
 rtl/prog_pkg.sv | 21 ++
 rtl/btn_edge_sync.sv | 39 +++
 rtl/prog_loader.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/prog_pkg.sv
// -----------------------------------------------------------------------------
// prog_pkg
// Shared types for the switch-driven memory programming logic.
//   mode_e  : meaning of the two `mode` switches at the moment a press is acted on
//   state_e : top-level loader FSM states
// -----------------------------------------------------------------------------
package prog_pkg;

    typedef enum logic [1:0] {
        MODE_APPEND = 2'b00,
        MODE_DIRECT = 2'b01,
        MODE_CLEAR  = 2'b10,
        MODE_RSVD   = 2'b11
    } mode_e;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage : prog_pkg

// File: rtl/btn_edge_sync.sv
// -----------------------------------------------------------------------------
// btn_edge_sync
// Brings a raw asynchronous button level into the clk domain through a 2-flop
// synchroniser and turns each rising edge into a single-cycle pulse.
//
// Ports:
//   clk     in   system clock, rising edge
//   rst     in   synchronous active-low reset
//   i_btn   in   raw button level (asynchronous)
//   o_rise  out  one-cycle pulse, high in the cycle after the second sync flop
//                first shows 1 (i.e. between the 2nd and 3rd sampling edges)
// -----------------------------------------------------------------------------
module btn_edge_sync (
    input  logic clk,
    input  logic rst,
    input  logic i_btn,
    output logic o_rise
);

    logic r_sync1;
    logic r_sync2;
    logic r_prev;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
            r_prev  <= 1'b0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            r_prev  <= r_sync2;
        end
    end

    // Combinational so the consumer can act on the very next edge.
    assign o_rise = r_sync2 & ~r_prev;

endmodule : btn_edge_sync

// File: rtl/prog_loader.sv
// -----------------------------------------------------------------------------
// prog_loader
// Converts each press of a raw `enter` button into one write of `switch` into a
// DEPTH-entry memory. Modes: append at the fill pointer, write to `addrSel`,
// or clear the whole memory with a DEPTH-cycle zero-fill sweep.
//
// Ports:
//   clk       in   system clock, rising edge
//   rst       in   synchronous active-low reset
//   switch    in   [DATA_W]   data to write
//   enter     in   raw asynchronous button level
//   mode      in   [2]        00 append, 01 direct, 10 clear-all, 11 ignored
//   addrSel   in   [ADDR_W]   target address in direct mode
//   dataWr    out  [DATA_W]   registered write data
//   addrWr    out  [ADDR_W]   registered write address
//   wrEn      out  registered write strobe (pulse per write)
//   count     out  [ADDR_W+1] entries written by append since reset/clear
//   full      out  count == DEPTH
//   busy      out  clear sweep in progress
//   overflow  out  one-cycle pulse: append rejected because full
//   addrErr   out  one-cycle pulse: direct address out of range
// -----------------------------------------------------------------------------
module prog_loader
    import prog_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int DEPTH  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] switch,
    input  logic              enter,
    input  logic [1:0]        mode,
    input  logic [ADDR_W-1:0] addrSel,
    output logic [DATA_W-1:0] dataWr,
    output logic [ADDR_W-1:0] addrWr,
    output logic              wrEn,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              busy,
    output logic              overflow,
    output logic              addrErr
);

    generate
        if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
            $error("prog_loader: DEPTH must lie in 2..2**ADDR_W");
        end
    endgenerate

    localparam logic [ADDR_W:0]   DEPTH_C   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_e              r_state;
    state_e              w_state_next;
    // Append pointer; it advances and resets together with the fill count, so
    // one register serves as both. One bit wider so it can hold DEPTH.
    logic [ADDR_W:0]     r_ptr;
    logic [ADDR_W:0]     w_ptr_next;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   w_data_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [ADDR_W-1:0]   w_addr_next;
    logic                r_wr_en;
    logic                w_wr_en_next;
    logic                r_ovf;
    logic                w_ovf_next;
    logic                r_aerr;
    logic                w_aerr_next;
    logic                w_press;
    logic                w_full;

    btn_edge_sync u_enter_sync (
        .clk    (clk),
        .rst    (rst),
        .i_btn  (enter),
        .o_rise (w_press)
    );

    assign w_full = (r_ptr == DEPTH_C);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_data  <= '0;
            r_addr  <= '0;
            r_wr_en <= 1'b0;
            r_ovf   <= 1'b0;
            r_aerr  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ptr   <= w_ptr_next;
            r_data  <= w_data_next;
            r_addr  <= w_addr_next;
            r_wr_en <= w_wr_en_next;
            r_ovf   <= w_ovf_next;
            r_aerr  <= w_aerr_next;
        end
    end

    always_comb begin
        // Data/address hold between writes; strobes default low.
        w_state_next = r_state;
        w_ptr_next   = r_ptr;
        w_data_next  = r_data;
        w_addr_next  = r_addr;
        w_wr_en_next = 1'b0;
        w_ovf_next   = 1'b0;
        w_aerr_next  = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_press) begin
                    unique case (mode_e'(mode))
                        MODE_APPEND: begin
                            if (!w_full) begin
                                w_data_next  = switch;
                                w_addr_next  = r_ptr[ADDR_W-1:0];
                                w_wr_en_next = 1'b1;
                                w_ptr_next   = r_ptr + 1'b1;
                            end else begin
                                w_ovf_next   = 1'b1;
                            end
                        end
                        MODE_DIRECT: begin
                            if ({1'b0, addrSel} < DEPTH_C) begin
                                w_data_next  = switch;
                                w_addr_next  = addrSel;
                                w_wr_en_next = 1'b1;
                            end else begin
                                w_aerr_next  = 1'b1;
                            end
                        end
                        MODE_CLEAR: begin
                            // First sweep write issues on the same edge that
                            // enters CLEAR.
                            w_state_next = CLEAR;
                            w_data_next  = '0;
                            w_addr_next  = '0;
                            w_wr_en_next = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            CLEAR: begin
                // Presses are ignored here; the edge detector keeps running so
                // a held button does not fire again after the sweep.
                if (r_addr == LAST_ADDR) begin
                    w_state_next = IDLE;
                    w_ptr_next   = '0;
                end else begin
                    w_addr_next  = r_addr + 1'b1;
                    w_wr_en_next = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    assign dataWr   = r_data;
    assign addrWr   = r_addr;
    assign wrEn     = r_wr_en;
    assign count    = r_ptr;
    assign full     = w_full;
    assign busy     = (r_state == CLEAR);
    assign overflow = r_ovf;
    assign addrErr  = r_aerr;

endmodule : prog_loader
